// File: rtl/fcs_frame_checker_if.sv
// Receive-side bus between the MAC byte stream and the frame checker.
// The master drives the MAC byte stream and lookup result; the slave (checker)
// returns the registered stream, header fields and the per-frame verdict.
interface fcs_frame_checker_if #(
    parameter int unsigned P_LEN_W = 11
);
    logic               rx_ctrl;
    logic [7:0]         data_in;
    logic [2:0]         dst_port_in;
    logic [7:0]         data_out;
    logic               data_valid;
    logic [2:0]         dst_port_out;
    logic [2:0]         src_port;
    logic [47:0]        dst_mac;
    logic [47:0]        src_mac;
    logic [15:0]        ethertype;
    logic               mac_valid;
    logic               hdr_valid;
    logic [P_LEN_W-1:0] frame_len;
    logic               status_valid;
    logic [1:0]         status_code;

    modport master (
        output rx_ctrl, data_in, dst_port_in,
        input  data_out, data_valid, dst_port_out, src_port, dst_mac, src_mac,
               ethertype, mac_valid, hdr_valid, frame_len, status_valid, status_code
    );

    modport slave (
        input  rx_ctrl, data_in, dst_port_in,
        output data_out, data_valid, dst_port_out, src_port, dst_mac, src_mac,
               ethertype, mac_valid, hdr_valid, frame_len, status_valid, status_code
    );
endinterface

// File: rtl/fcs_frame_checker.sv
// Ingress frame checker: registers the MAC byte stream, runs a reflected CRC-32
// over every byte including FCS, extracts dst/src MAC and EtherType, counts
// frame length and emits one verdict pulse per frame.
module fcs_frame_checker #(
    parameter logic [2:0]  P_SRC_PORT  = 3'd0,
    parameter int unsigned P_MIN_FRAME = 64,
    parameter int unsigned P_MAX_FRAME = 1518,
    parameter int unsigned P_LEN_W     = 11
) (
    input logic                clk,
    input logic                reset_n,
    fcs_frame_checker_if.slave bus
);

    localparam logic [P_LEN_W-1:0] LEN_SAT     = {P_LEN_W{1'b1}};
    localparam logic [P_LEN_W-1:0] MIN_LEN     = P_LEN_W'(P_MIN_FRAME);
    localparam logic [P_LEN_W-1:0] MAX_LEN     = P_LEN_W'(P_MAX_FRAME);
    localparam logic [31:0]        CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0]        CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0]        CRC_RESIDUE = 32'hDEBB_20E3;

    typedef enum logic [1:0] {StWaitIdle, StIdle, StRecv} state_t;

    state_t             state_q;
    logic [31:0]        crc_q;
    logic [P_LEN_W-1:0] len_q;
    logic [7:0]         data_out_q;
    logic               data_valid_q;
    logic [47:0]        dst_mac_q;
    logic [47:0]        src_mac_q;
    logic [15:0]        ethertype_q;
    logic               mac_valid_q;
    logic               hdr_valid_q;
    logic               status_valid_q;
    logic [1:0]         status_code_q;

    logic               byte_en;
    logic               first_byte;
    logic               end_of_frame;
    logic [P_LEN_W-1:0] byte_num;
    logic [1:0]         verdict;

    // One byte through the reflected CRC-32, LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc ^ {24'd0, b};
        for (int k = 0; k < 8; k++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    // Byte-accept decode, 1-based byte index and end-of-frame verdict.
    always_comb begin
        first_byte   = bus.rx_ctrl && (state_q == StIdle);
        byte_en      = bus.rx_ctrl && ((state_q == StIdle) || (state_q == StRecv));
        end_of_frame = !bus.rx_ctrl && (state_q == StRecv);
        if (first_byte) begin
            byte_num = P_LEN_W'(1);
        end else if (len_q == LEN_SAT) begin
            byte_num = LEN_SAT;
        end else begin
            byte_num = len_q + 1'b1;
        end
        if (len_q < MIN_LEN) begin
            verdict = 2'b10;
        end else if ((len_q > MAX_LEN) || (len_q == LEN_SAT)) begin
            verdict = 2'b11;
        end else if (crc_q != CRC_RESIDUE) begin
            verdict = 2'b01;
        end else begin
            verdict = 2'b00;
        end
    end

    // Frame FSM with its registered pass-through, header, length and verdict outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StWaitIdle;
            crc_q          <= '0;
            len_q          <= '0;
            data_out_q     <= '0;
            data_valid_q   <= 1'b0;
            dst_mac_q      <= '0;
            src_mac_q      <= '0;
            ethertype_q    <= '0;
            mac_valid_q    <= 1'b0;
            hdr_valid_q    <= 1'b0;
            status_valid_q <= 1'b0;
            status_code_q  <= '0;
        end else begin
            data_out_q     <= bus.data_in;
            data_valid_q   <= byte_en;
            mac_valid_q    <= 1'b0;
            hdr_valid_q    <= 1'b0;
            status_valid_q <= 1'b0;

            case (state_q)
                StWaitIdle: if (!bus.rx_ctrl) state_q <= StIdle;
                StIdle:     if (bus.rx_ctrl) state_q <= StRecv;
                StRecv: begin
                    if (end_of_frame) begin
                        state_q        <= StIdle;
                        status_valid_q <= 1'b1;
                        status_code_q  <= verdict;
                    end
                end
                default: state_q <= StWaitIdle;
            endcase

            if (byte_en) begin
                crc_q       <= crc_byte(first_byte ? CRC_INIT : crc_q, bus.data_in);
                len_q       <= byte_num;
                mac_valid_q <= (byte_num == P_LEN_W'(12));
                hdr_valid_q <= (byte_num == P_LEN_W'(14));
                if (first_byte) begin
                    // A new frame wipes the previous frame's header fields.
                    dst_mac_q   <= {bus.data_in, 40'd0};
                    src_mac_q   <= '0;
                    ethertype_q <= '0;
                end else begin
                    for (int i = 2; i <= 6; i++) begin
                        if (byte_num == P_LEN_W'(i)) dst_mac_q[8*(6-i) +: 8] <= bus.data_in;
                    end
                    for (int i = 7; i <= 12; i++) begin
                        if (byte_num == P_LEN_W'(i)) src_mac_q[8*(12-i) +: 8] <= bus.data_in;
                    end
                    for (int i = 13; i <= 14; i++) begin
                        if (byte_num == P_LEN_W'(i)) ethertype_q[8*(14-i) +: 8] <= bus.data_in;
                    end
                end
            end
        end
    end

    assign bus.data_out     = data_out_q;
    assign bus.data_valid   = data_valid_q;
    assign bus.dst_port_out = bus.dst_port_in;
    assign bus.src_port     = P_SRC_PORT;
    assign bus.dst_mac      = dst_mac_q;
    assign bus.src_mac      = src_mac_q;
    assign bus.ethertype    = ethertype_q;
    assign bus.mac_valid    = mac_valid_q;
    assign bus.hdr_valid    = hdr_valid_q;
    assign bus.frame_len    = len_q;
    assign bus.status_valid = status_valid_q;
    assign bus.status_code  = status_code_q;

endmodule

// File: tb/tb_fcs_frame_checker.sv
// Directed bench for fcs_frame_checker: builds Ethernet frames with a bench-side
// CRC-32, streams them in and checks header extraction, timing and verdicts.
module tb_fcs_frame_checker;

    logic clk;
    logic reset_n;

    fcs_frame_checker_if #(.P_LEN_W(11)) bus_if ();

    fcs_frame_checker #(
        .P_SRC_PORT (3'd3),
        .P_MIN_FRAME(64),
        .P_MAX_FRAME(1518),
        .P_LEN_W    (11)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus_if)
    );

    int tests = 0;
    int fails = 0;

    logic [7:0] frame [0:2047];

    // Monitor bookkeeping, sampled on the falling edge.
    int cyc = 0;
    int mac_cnt = 0, hdr_cnt = 0, stat_cnt = 0, dv_cnt = 0;
    int mac_cyc = 0, hdr_cyc = 0, stat_cyc = 0;
    int b12_cyc = 0, b14_cyc = 0, last_cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus_if.mac_valid) begin mac_cnt <= mac_cnt + 1; mac_cyc <= cyc; end
        if (bus_if.hdr_valid) begin hdr_cnt <= hdr_cnt + 1; hdr_cyc <= cyc; end
        if (bus_if.status_valid) begin stat_cnt <= stat_cnt + 1; stat_cyc <= cyc; end
        if (bus_if.data_valid) dv_cnt <= dv_cnt + 1;
    end

    // Serial LSB-first CRC-32 (reflected 0x04C11DB7).
    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic fb;
        for (int k = 0; k < 8; k++) begin
            fb = c[0] ^ b[k];
            c  = c >> 1;
            if (fb) c = c ^ 32'hEDB88320;
        end
        return c;
    endfunction

    // Header + payload pattern, then FCS (complemented CRC, low byte first).
    task automatic build_frame(input int len, input logic [47:0] d, input logic [47:0] s,
                               input logic [15:0] et, input logic [7:0] seed);
        logic [31:0] crc;
        for (int i = 0; i < len; i++) begin
            if (i < 6) frame[i] = d[8*(5-i) +: 8];
            else if (i < 12) frame[i] = s[8*(11-i) +: 8];
            else if (i < 14) frame[i] = et[8*(13-i) +: 8];
            else frame[i] = seed + 8'(i);
        end
        crc = 32'hFFFFFFFF;
        for (int i = 0; i < len - 4; i++) crc = crc_upd(crc, frame[i]);
        crc = ~crc;
        frame[len-4] = crc[7:0];
        frame[len-3] = crc[15:8];
        frame[len-2] = crc[23:16];
        frame[len-1] = crc[31:24];
    endtask

    // Streams frame[0:len-1]; checks the 1-cycle pass-through on each byte.
    task automatic send_frame(input int len, input bit hold);
        bit bad = 0;
        logic [7:0] got = 8'h00;
        int at = -1;
        for (int i = 0; i < len; i++) begin
            bus_if.rx_ctrl = 1'b1;
            bus_if.data_in = frame[i];
            @(posedge clk); #1;
            if (i == 11) b12_cyc = cyc;
            if (i == 13) b14_cyc = cyc;
            if (i == len - 1) last_cyc = cyc;
            if (!bad && (bus_if.data_out !== frame[i] || bus_if.data_valid !== 1'b1)) begin
                bad = 1; got = bus_if.data_out; at = i;
            end
        end
        if (!hold) bus_if.rx_ctrl = 1'b0;
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL passthrough byte %0d: data_out=%h want %h", at, got, frame[at]);
        end
    endtask

    task automatic idle(input int n);
        bus_if.rx_ctrl = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset;
        bus_if.rx_ctrl = 1'b0; bus_if.data_in = 8'h5A; bus_if.dst_port_in = 3'd6;
        reset_n = 1'b0;
        repeat (2) @(posedge clk); #1;
        tests += 6;
        if (bus_if.data_valid !== 1'b0 || bus_if.data_out !== 8'h00) begin fails++;
            $display("FAIL reset_data: dv=%b do=%h want 0/00", bus_if.data_valid, bus_if.data_out); end
        if (bus_if.mac_valid !== 1'b0 || bus_if.hdr_valid !== 1'b0 || bus_if.status_valid !== 1'b0) begin fails++;
            $display("FAIL reset_pulses: mac=%b hdr=%b st=%b want 0", bus_if.mac_valid, bus_if.hdr_valid, bus_if.status_valid); end
        if (bus_if.frame_len !== 11'd0 || bus_if.status_code !== 2'b00) begin fails++;
            $display("FAIL reset_len_code: len=%0d code=%b want 0/00", bus_if.frame_len, bus_if.status_code); end
        if (bus_if.dst_mac !== 48'd0 || bus_if.src_mac !== 48'd0 || bus_if.ethertype !== 16'd0) begin fails++;
            $display("FAIL reset_hdr: dst=%h src=%h et=%h want 0", bus_if.dst_mac, bus_if.src_mac, bus_if.ethertype); end
        if (bus_if.src_port !== 3'd3) begin fails++;
            $display("FAIL src_port: got %0d want 3", bus_if.src_port); end
        if (bus_if.dst_port_out !== 3'd6) begin fails++;
            $display("FAIL dst_port: got %0d want 6", bus_if.dst_port_out); end
        reset_n = 1'b1;
        idle(3);
    endtask

    task automatic test_good_64;
        int m0 = mac_cnt, h0 = hdr_cnt, s0 = stat_cnt, d0 = dv_cnt;
        build_frame(64, 48'h0011_2233_4455, 48'hA0B1_C2D3_E4F5, 16'h0800, 8'h10);
        send_frame(64, 0);
        idle(3);
        tests += 9;
        if (mac_cnt - m0 != 1 || mac_cyc != b12_cyc) begin fails++;
            $display("FAIL good_mac_valid: pulses=%0d at %0d want 1 at %0d", mac_cnt - m0, mac_cyc, b12_cyc); end
        if (hdr_cnt - h0 != 1 || hdr_cyc != b14_cyc) begin fails++;
            $display("FAIL good_hdr_valid: pulses=%0d at %0d want 1 at %0d", hdr_cnt - h0, hdr_cyc, b14_cyc); end
        // Verdict registered on the edge that sees rx_ctrl low, one edge after the last byte.
        if (stat_cnt - s0 != 1 || stat_cyc != last_cyc + 1) begin fails++;
            $display("FAIL good_status_timing: pulses=%0d at %0d want 1 at %0d", stat_cnt - s0, stat_cyc, last_cyc + 1); end
        if (bus_if.status_code !== 2'b00) begin fails++;
            $display("FAIL good_code: got %b want 00", bus_if.status_code); end
        if (bus_if.frame_len !== 11'd64) begin fails++;
            $display("FAIL good_len: got %0d want 64", bus_if.frame_len); end
        if (bus_if.dst_mac !== 48'h0011_2233_4455) begin fails++;
            $display("FAIL good_dst_mac: got %h want 001122334455", bus_if.dst_mac); end
        if (bus_if.src_mac !== 48'hA0B1_C2D3_E4F5) begin fails++;
            $display("FAIL good_src_mac: got %h want a0b1c2d3e4f5", bus_if.src_mac); end
        if (bus_if.ethertype !== 16'h0800) begin fails++;
            $display("FAIL good_ethertype: got %h want 0800", bus_if.ethertype); end
        if (dv_cnt - d0 != 64) begin fails++;
            $display("FAIL good_data_valid: got %0d cycles want 64", dv_cnt - d0); end
    endtask

    task automatic test_fcs_error;
        int s0 = stat_cnt;
        build_frame(64, 48'h0011_2233_4455, 48'hA0B1_C2D3_E4F5, 16'h0800, 8'h10);
        frame[19] = frame[19] ^ 8'h01;
        send_frame(64, 0);
        idle(3);
        tests += 2;
        if (stat_cnt - s0 != 1 || bus_if.status_code !== 2'b01) begin fails++;
            $display("FAIL fcs_err_code: pulses=%0d code=%b want 1/01", stat_cnt - s0, bus_if.status_code); end
        if (bus_if.frame_len !== 11'd64) begin fails++;
            $display("FAIL fcs_err_len: got %0d want 64", bus_if.frame_len); end
    endtask

    task automatic test_length(input string name, input int len, input logic [1:0] code,
                               input int macs, input int hdrs);
        int m0 = mac_cnt, h0 = hdr_cnt, s0 = stat_cnt;
        build_frame(len, 48'h0A0B_0C0D_0E0F, 48'h1112_1314_1516, 16'h86DD, 8'h33);
        send_frame(len, 0);
        idle(3);
        tests += 3;
        if (stat_cnt - s0 != 1 || bus_if.status_code !== code) begin fails++;
            $display("FAIL %s_code: pulses=%0d code=%b want 1/%b", name, stat_cnt - s0, bus_if.status_code, code); end
        if (bus_if.frame_len !== 11'(len)) begin fails++;
            $display("FAIL %s_len: got %0d want %0d", name, bus_if.frame_len, len); end
        if (mac_cnt - m0 != macs || hdr_cnt - h0 != hdrs) begin fails++;
            $display("FAIL %s_hdr_pulses: mac=%0d hdr=%0d want %0d/%0d", name, mac_cnt - m0, hdr_cnt - h0, macs, hdrs); end
    endtask

    task automatic test_back_to_back;
        int s0 = stat_cnt;
        build_frame(64, 48'h0011_2233_4455, 48'hA0B1_C2D3_E4F5, 16'h0800, 8'h10);
        send_frame(64, 0);
        @(posedge clk); #1;
        tests += 1;
        if (bus_if.status_valid !== 1'b1 || bus_if.status_code !== 2'b00) begin fails++;
            $display("FAIL b2b_first: st=%b code=%b want 1/00", bus_if.status_valid, bus_if.status_code); end
        build_frame(64, 48'hFEDC_BA98_7654, 48'h0102_0304_0506, 16'h88CC, 8'h77);
        send_frame(64, 0);
        idle(3);
        tests += 4;
        if (stat_cnt - s0 != 2 || bus_if.status_code !== 2'b00) begin fails++;
            $display("FAIL b2b_second: pulses=%0d code=%b want 2/00", stat_cnt - s0, bus_if.status_code); end
        if (bus_if.dst_mac !== 48'hFEDC_BA98_7654) begin fails++;
            $display("FAIL b2b_dst_mac: got %h want fedcba987654", bus_if.dst_mac); end
        if (bus_if.src_mac !== 48'h0102_0304_0506) begin fails++;
            $display("FAIL b2b_src_mac: got %h want 010203040506", bus_if.src_mac); end
        if (bus_if.ethertype !== 16'h88CC || bus_if.frame_len !== 11'd64) begin fails++;
            $display("FAIL b2b_et_len: et=%h len=%0d want 88cc/64", bus_if.ethertype, bus_if.frame_len); end
    endtask

    task automatic test_reset_mid_frame;
        int s0 = stat_cnt;
        bit bad = 0;
        build_frame(64, 48'h0011_2233_4455, 48'hA0B1_C2D3_E4F5, 16'h0800, 8'h10);
        send_frame(30, 1);
        reset_n = 1'b0;
        #1;
        tests += 1;
        if (bus_if.data_valid !== 1'b0 || bus_if.frame_len !== 11'd0) begin fails++;
            $display("FAIL midrst_clear: dv=%b len=%0d want 0/0", bus_if.data_valid, bus_if.frame_len); end
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus_if.data_in = 8'hA0 + 8'(k);
            @(posedge clk); #1;
            if (bus_if.data_valid !== 1'b0 || bus_if.status_valid !== 1'b0) bad = 1;
        end
        tests += 1;
        if (bad) begin fails++;
            $display("FAIL midrst_hold: data_valid/status_valid went high, want 0"); end
        idle(3);
        tests += 1;
        if (stat_cnt != s0) begin fails++;
            $display("FAIL midrst_no_status: pulses=%0d want 0", stat_cnt - s0); end
        send_frame(64, 0);
        idle(3);
        tests += 1;
        if (stat_cnt - s0 != 1 || bus_if.status_code !== 2'b00 || bus_if.frame_len !== 11'd64) begin fails++;
            $display("FAIL midrst_next: pulses=%0d code=%b len=%0d want 1/00/64",
                     stat_cnt - s0, bus_if.status_code, bus_if.frame_len); end
    endtask

    initial begin
        reset_n = 1'b0;
        bus_if.rx_ctrl = 1'b0;
        bus_if.data_in = 8'h00;
        bus_if.dst_port_in = 3'd0;
        test_reset();
        test_good_64();
        test_fcs_error();
        test_length("runt60", 60, 2'b10, 1, 1);
        test_length("giant1519", 1519, 2'b11, 1, 1);
        test_length("max1518", 1518, 2'b00, 1, 1);
        test_length("short10", 10, 2'b10, 0, 0);
        test_length("short13", 13, 2'b10, 1, 0);
        test_back_to_back();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
